// File: rtl/dcache_miss_ctrl.sv
// L1 data cache miss sequencer: optional dirty-victim write-back, then a word refill
// over a single valid/ready memory port, with a response timeout.
module dcache_miss_ctrl #(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  miss_valid,
    output logic                  miss_ready,
    input  logic [ADDR_WIDTH-1:0] miss_addr,
    input  logic                  victim_dirty,
    input  logic [ADDR_WIDTH-1:0] victim_addr,
    input  logic [DATA_WIDTH-1:0] victim_data,
    output logic                  refill_valid,
    output logic [ADDR_WIDTH-1:0] refill_addr,
    output logic [DATA_WIDTH-1:0] refill_data,
    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    output logic                  mem_req_write,
    output logic [ADDR_WIDTH-1:0] mem_req_addr,
    output logic [DATA_WIDTH-1:0] mem_req_wdata,
    input  logic                  mem_resp_valid,
    input  logic [DATA_WIDTH-1:0] mem_resp_data,
    output logic                  busy,
    output logic                  timeout_err
);

    localparam int unsigned CNT_WIDTH = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WB_REQ  = 3'd1,
        S_WB_RESP = 3'd2,
        S_RF_REQ  = 3'd3,
        S_RF_RESP = 3'd4,
        S_DONE    = 3'd5
    } state_e;

    state_e                  state_q, state_d;
    logic [CNT_WIDTH-1:0]    wait_cnt_q, wait_cnt_d;
    logic                    timeout_hit_c;
    logic                    accept_c;

    logic [ADDR_WIDTH-1:0]   miss_addr_q, miss_addr_d;
    logic [ADDR_WIDTH-3:0]   victim_word_q, victim_word_d;
    logic [DATA_WIDTH-1:0]   victim_data_q, victim_data_d;

    logic                    miss_ready_q, miss_ready_d;
    logic                    busy_q, busy_d;
    logic                    refill_valid_q, refill_valid_d;
    logic [DATA_WIDTH-1:0]   refill_data_q, refill_data_d;
    logic                    mem_req_valid_q, mem_req_valid_d;
    logic                    mem_req_write_q, mem_req_write_d;
    logic [ADDR_WIDTH-1:0]   mem_req_addr_q, mem_req_addr_d;
    logic [DATA_WIDTH-1:0]   mem_req_wdata_q, mem_req_wdata_d;
    logic                    timeout_err_q, timeout_err_d;

    // Victim byte offset is dropped: memory is word-addressed on this port.
    logic unused_victim_lsb_c;
    assign unused_victim_lsb_c = ^victim_addr[1:0];

    // miss_ready_q is only high in IDLE, so it doubles as the accept qualifier.
    assign accept_c = miss_valid & miss_ready_q;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    // Next-state and response wait counter.
    always_comb begin
        state_d       = state_q;
        wait_cnt_d    = wait_cnt_q;
        timeout_hit_c = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept_c) begin
                    state_d = victim_dirty ? S_WB_REQ : S_RF_REQ;
                end
            end
            S_WB_REQ, S_RF_REQ: begin
                if (mem_req_ready) begin
                    state_d    = (state_q == S_WB_REQ) ? S_WB_RESP : S_RF_RESP;
                    wait_cnt_d = '0;
                end
            end
            S_WB_RESP, S_RF_RESP: begin
                // A response on the limit cycle still completes normally.
                if (mem_resp_valid) begin
                    state_d = (state_q == S_WB_RESP) ? S_RF_REQ : S_DONE;
                end else if (wait_cnt_q == CNT_LAST) begin
                    state_d       = S_IDLE;
                    timeout_hit_c = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + CNT_WIDTH'(1);
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output decode from the upcoming state so every port comes straight off a flop.
    always_comb begin
        miss_addr_d     = accept_c ? miss_addr : miss_addr_q;
        victim_word_d   = accept_c ? victim_addr[ADDR_WIDTH-1:2] : victim_word_q;
        victim_data_d   = accept_c ? victim_data : victim_data_q;

        miss_ready_d    = (state_d == S_IDLE);
        busy_d          = (state_d != S_IDLE);
        refill_valid_d  = (state_d == S_DONE);
        mem_req_valid_d = (state_d == S_WB_REQ) || (state_d == S_RF_REQ);
        mem_req_write_d = (state_d == S_WB_REQ);
        mem_req_addr_d  = '0;
        mem_req_wdata_d = '0;
        if (state_d == S_WB_REQ) begin
            mem_req_addr_d  = {victim_word_d, 2'b00};
            mem_req_wdata_d = victim_data_d;
        end else if (state_d == S_RF_REQ) begin
            mem_req_addr_d  = {miss_addr_d[ADDR_WIDTH-1:2], 2'b00};
        end

        refill_data_d = refill_data_q;
        if ((state_q == S_RF_RESP) && mem_resp_valid) begin
            refill_data_d = mem_resp_data;
        end
        timeout_err_d = timeout_err_q | timeout_hit_c;
    end

    // Latched miss context and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            miss_addr_q     <= '0;
            victim_word_q   <= '0;
            victim_data_q   <= '0;
            miss_ready_q    <= 1'b0;
            busy_q          <= 1'b0;
            refill_valid_q  <= 1'b0;
            refill_data_q   <= '0;
            mem_req_valid_q <= 1'b0;
            mem_req_write_q <= 1'b0;
            mem_req_addr_q  <= '0;
            mem_req_wdata_q <= '0;
            timeout_err_q   <= 1'b0;
        end else begin
            miss_addr_q     <= miss_addr_d;
            victim_word_q   <= victim_word_d;
            victim_data_q   <= victim_data_d;
            miss_ready_q    <= miss_ready_d;
            busy_q          <= busy_d;
            refill_valid_q  <= refill_valid_d;
            refill_data_q   <= refill_data_d;
            mem_req_valid_q <= mem_req_valid_d;
            mem_req_write_q <= mem_req_write_d;
            mem_req_addr_q  <= mem_req_addr_d;
            mem_req_wdata_q <= mem_req_wdata_d;
            timeout_err_q   <= timeout_err_d;
        end
    end

    assign miss_ready    = miss_ready_q;
    assign busy          = busy_q;
    assign refill_valid  = refill_valid_q;
    assign refill_addr   = miss_addr_q;
    assign refill_data   = refill_data_q;
    assign mem_req_valid = mem_req_valid_q;
    assign mem_req_write = mem_req_write_q;
    assign mem_req_addr  = mem_req_addr_q;
    assign mem_req_wdata = mem_req_wdata_q;
    assign timeout_err   = timeout_err_q;

endmodule

// File: tb/tb_dcache_miss_ctrl.sv
// Directed bench for dcache_miss_ctrl: clean, dirty, backpressure, timeout,
// mid-transaction reset and stray responses, cycle-exact against hand timing.
module tb_dcache_miss_ctrl;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;

    logic          clk;
    logic          reset;
    logic          miss_valid;
    logic          miss_ready;
    logic [AW-1:0] miss_addr;
    logic          victim_dirty;
    logic [AW-1:0] victim_addr;
    logic [DW-1:0] victim_data;
    logic          refill_valid;
    logic [AW-1:0] refill_addr;
    logic [DW-1:0] refill_data;
    logic          mem_req_valid;
    logic          mem_req_ready;
    logic          mem_req_write;
    logic [AW-1:0] mem_req_addr;
    logic [DW-1:0] mem_req_wdata;
    logic          mem_resp_valid;
    logic [DW-1:0] mem_resp_data;
    logic          busy;
    logic          timeout_err;

    int n_tests;
    int n_fail;
    int refill_cnt;
    int wr_req_cnt;

    dcache_miss_ctrl #(
        .ADDR_WIDTH    (AW),
        .DATA_WIDTH    (DW),
        .TIMEOUT_CYCLES(4)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .miss_valid    (miss_valid),
        .miss_ready    (miss_ready),
        .miss_addr     (miss_addr),
        .victim_dirty  (victim_dirty),
        .victim_addr   (victim_addr),
        .victim_data   (victim_data),
        .refill_valid  (refill_valid),
        .refill_addr   (refill_addr),
        .refill_data   (refill_data),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_req_write (mem_req_write),
        .mem_req_addr  (mem_req_addr),
        .mem_req_wdata (mem_req_wdata),
        .mem_resp_valid(mem_resp_valid),
        .mem_resp_data (mem_resp_data),
        .busy          (busy),
        .timeout_err   (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count refill pulses and write-request cycles away from the active edge.
    always @(negedge clk) begin
        if (refill_valid) refill_cnt++;
        if (mem_req_valid && mem_req_write) wr_req_cnt++;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_miss(input logic [31:0] maddr, input logic dirty,
                              input logic [31:0] vaddr, input logic [31:0] vdata);
        miss_valid   = 1'b1;
        miss_addr    = maddr;
        victim_dirty = dirty;
        victim_addr  = vaddr;
        victim_data  = vdata;
    endtask

    task automatic scramble_inputs();
        miss_valid   = 1'b0;
        miss_addr    = 32'hFFFF_FFF0;
        victim_dirty = 1'b1;
        victim_addr  = 32'hEEEE_EEE0;
        victim_data  = 32'h0BAD_0BAD;
    endtask

    initial begin
        n_tests = 0; n_fail = 0; refill_cnt = 0; wr_req_cnt = 0;
        reset = 1'b1;
        miss_valid = 1'b0; miss_addr = '0; victim_dirty = 1'b0;
        victim_addr = '0; victim_data = '0;
        mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_data = '0;

        // Reset values
        tick(); tick();
        check_eq("rst_miss_ready", 32'(miss_ready), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_req_valid", 32'(mem_req_valid), 32'd0);
        check_eq("rst_req_addr", mem_req_addr, 32'd0);
        check_eq("rst_refill_addr", refill_addr, 32'd0);
        check_eq("rst_refill_data", refill_data, 32'd0);
        check_eq("rst_timeout_err", 32'(timeout_err), 32'd0);
        reset = 1'b0;
        tick();
        check_eq("post_rst_miss_ready", 32'(miss_ready), 32'd1);

        // Clean miss, zero-wait memory: refill at T+3, ready again at T+4
        mem_req_ready = 1'b1;
        start_miss(32'h0000_1004, 1'b0, 32'h0, 32'h0);
        tick();                                              // T+1
        scramble_inputs();
        check_eq("clean_req_valid", 32'(mem_req_valid), 32'd1);
        check_eq("clean_req_write", 32'(mem_req_write), 32'd0);
        check_eq("clean_req_addr", mem_req_addr, 32'h0000_1004);
        check_eq("clean_req_wdata", mem_req_wdata, 32'h0);
        check_eq("clean_busy", 32'(busy), 32'd1);
        check_eq("clean_miss_ready", 32'(miss_ready), 32'd0);
        tick();                                              // T+2
        check_eq("clean_req_dropped", 32'(mem_req_valid), 32'd0);
        mem_resp_valid = 1'b1; mem_resp_data = 32'hDEAD_BEEF;
        tick();                                              // T+3
        mem_resp_valid = 1'b0;
        check_eq("clean_refill_valid", 32'(refill_valid), 32'd1);
        check_eq("clean_refill_data", refill_data, 32'hDEAD_BEEF);
        check_eq("clean_refill_addr", refill_addr, 32'h0000_1004);
        tick();                                              // T+4
        check_eq("clean_pulse_end", 32'(refill_valid), 32'd0);
        check_eq("clean_miss_ready_back", 32'(miss_ready), 32'd1);
        check_eq("clean_no_write", 32'(wr_req_cnt), 32'd0);

        // Dirty miss: write-back first, refill at T+5
        start_miss(32'h0000_3000, 1'b1, 32'h0000_2000, 32'h1234_5678);
        tick();                                              // T+1 WB_REQ
        scramble_inputs();
        check_eq("dirty_wb_valid", 32'(mem_req_valid), 32'd1);
        check_eq("dirty_wb_write", 32'(mem_req_write), 32'd1);
        check_eq("dirty_wb_addr", mem_req_addr, 32'h0000_2000);
        check_eq("dirty_wb_wdata", mem_req_wdata, 32'h1234_5678);
        tick();                                              // T+2 WB_RESP
        mem_resp_valid = 1'b1; mem_resp_data = 32'h0;
        tick();                                              // T+3 RF_REQ
        mem_resp_valid = 1'b0;
        check_eq("dirty_rd_write", 32'(mem_req_write), 32'd0);
        check_eq("dirty_rd_addr", mem_req_addr, 32'h0000_3000);
        check_eq("dirty_rd_wdata", mem_req_wdata, 32'h0);
        check_eq("dirty_no_early_refill", 32'(refill_valid), 32'd0);
        tick();                                              // T+4 RF_RESP
        mem_resp_valid = 1'b1; mem_resp_data = 32'hCAFE_F00D;
        tick();                                              // T+5 DONE
        mem_resp_valid = 1'b0;
        check_eq("dirty_refill_valid", 32'(refill_valid), 32'd1);
        check_eq("dirty_refill_data", refill_data, 32'hCAFE_F00D);
        check_eq("dirty_refill_addr", refill_addr, 32'h0000_3000);
        tick();

        // Backpressure: ready low 5 cycles, valid held 6; unaligned miss address
        mem_req_ready = 1'b0;
        start_miss(32'h0000_4006, 1'b0, 32'h0, 32'h0);
        tick();
        scramble_inputs();
        for (int i = 0; i < 5; i++) begin
            check_eq("bp_valid_held", 32'(mem_req_valid), 32'd1);
            check_eq("bp_addr_stable", mem_req_addr, 32'h0000_4004);
            check_eq("bp_write_stable", 32'(mem_req_write), 32'd0);
            miss_addr = 32'h0000_7000 + 32'(i);
            tick();
        end
        mem_req_ready = 1'b1;
        check_eq("bp_valid_6th", 32'(mem_req_valid), 32'd1);
        check_eq("bp_addr_6th", mem_req_addr, 32'h0000_4004);
        tick();                                              // RF_RESP
        check_eq("bp_valid_drop", 32'(mem_req_valid), 32'd0);
        mem_resp_valid = 1'b1; mem_resp_data = 32'h55AA_33CC;
        tick();                                              // DONE
        mem_resp_valid = 1'b0;
        check_eq("bp_refill_valid", 32'(refill_valid), 32'd1);
        check_eq("bp_refill_data", refill_data, 32'h55AA_33CC);
        check_eq("bp_refill_addr", refill_addr, 32'h0000_4006);
        tick();

        // Response on the fourth (limit) wait cycle still wins over timeout
        start_miss(32'h0000_5100, 1'b0, 32'h0, 32'h0);
        tick(); scramble_inputs();                           // RF_REQ
        tick(); tick(); tick();                              // RF_RESP waits 1..3
        check_eq("edge_busy_w3", 32'(busy), 32'd1);
        tick();                                              // wait 4
        mem_resp_valid = 1'b1; mem_resp_data = 32'hA5A5_0004;
        tick();
        mem_resp_valid = 1'b0;
        check_eq("edge_refill_valid", 32'(refill_valid), 32'd1);
        check_eq("edge_refill_data", refill_data, 32'hA5A5_0004);
        check_eq("edge_no_err", 32'(timeout_err), 32'd0);
        tick();

        // Timeout: 4 silent wait cycles, then error and back to IDLE
        start_miss(32'h0000_5000, 1'b0, 32'h0, 32'h0);
        tick(); scramble_inputs();                           // RF_REQ
        for (int i = 0; i < 4; i++) begin
            tick();                                          // RF_RESP wait i+1
            check_eq("tmo_err_not_yet", 32'(timeout_err), 32'd0);
            check_eq("tmo_still_busy", 32'(busy), 32'd1);
        end
        tick();
        check_eq("tmo_err_set", 32'(timeout_err), 32'd1);
        check_eq("tmo_miss_ready", 32'(miss_ready), 32'd1);
        check_eq("tmo_no_refill", 32'(refill_valid), 32'd0);
        tick(); tick();
        check_eq("tmo_err_sticky", 32'(timeout_err), 32'd1);
        check_eq("refill_count_mid", 32'(refill_cnt), 32'd4);

        // Reset while waiting for the write-back ack
        start_miss(32'h0000_6000, 1'b1, 32'h0000_6800, 32'h7777_8888);
        tick(); scramble_inputs();                           // WB_REQ
        tick();                                              // WB_RESP
        reset = 1'b1;
        tick();
        reset = 1'b0;
        mem_resp_valid = 1'b1; mem_resp_data = 32'hDEAD_0001;  // stale ack, dropped
        check_eq("rstmid_req_valid", 32'(mem_req_valid), 32'd0);
        check_eq("rstmid_busy", 32'(busy), 32'd0);
        check_eq("rstmid_refill", 32'(refill_valid), 32'd0);
        check_eq("rstmid_err_clr", 32'(timeout_err), 32'd0);
        check_eq("rstmid_miss_ready", 32'(miss_ready), 32'd0);
        tick();
        check_eq("rstmid_ready_back", 32'(miss_ready), 32'd1);
        check_eq("rstmid_busy_after", 32'(busy), 32'd0);

        // Stray responses in IDLE and RF_REQ must not become the refill data
        mem_resp_data = 32'hBAD0_0002;                       // resp still high in IDLE
        mem_req_ready = 1'b0;
        start_miss(32'h0000_6004, 1'b0, 32'h0, 32'h0);
        tick(); scramble_inputs();                           // RF_REQ, stalled
        mem_resp_valid = 1'b1; mem_resp_data = 32'hBAD0_0003;
        tick();                                              // still RF_REQ
        mem_resp_valid = 1'b0; mem_req_ready = 1'b1;
        check_eq("stray_still_req", 32'(mem_req_valid), 32'd1);
        tick();                                              // RF_RESP
        mem_resp_valid = 1'b1; mem_resp_data = 32'h600D_600D;
        tick();                                              // DONE
        mem_resp_valid = 1'b0;
        check_eq("stray_refill_valid", 32'(refill_valid), 32'd1);
        check_eq("stray_refill_data", refill_data, 32'h600D_600D);
        check_eq("stray_refill_addr", refill_addr, 32'h0000_6004);
        tick(); tick();

        check_eq("refill_count_total", 32'(refill_cnt), 32'd5);
        check_eq("write_req_cycles", 32'(wr_req_cnt), 32'd2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

endmodule
